serial_tx: RTL and testbench
============================

SERIAL_TX -- requirements
Module: serial_tx

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst.
REQ-002 The block SHALL have parameter CLKS_PER_BIT, default 434, meaning clk cycles per serial bit; legal range 2..65535.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 4, meaning 32-bit words buffered; power of two, 2..16.
REQ-004 Port list, one port per line, in this order:
  clk      input   1   system clock; all state on rising edge
  rst      input   1   asynchronous active-low reset
  data_in  input   32  word written by the processor to I/O address 255
  wr_en    input   1   one-cycle strobe; data_in is valid this cycle
  clr_ovf  input   1   synchronous clear of overflow
  tx       output  1   serial line; idle high
  busy     output  1   high while FSM is not IDLE or FIFO is not empty
  full     output  1   FIFO holds FIFO_DEPTH words
  empty    output  1   FIFO holds 0 words
  overflow output  1   sticky; a write was dropped

Function
REQ-005 A push SHALL occur when wr_en=1 and (count<FIFO_DEPTH or a pop occurs the same cycle).
REQ-006 When wr_en=1, full=1 and no pop occurs the same cycle, the word SHALL be dropped and overflow SHALL be set at the next edge.
REQ-007 overflow SHALL clear on clr_ovf=1 unless a drop occurs the same cycle; a drop in that cycle SHALL win.
REQ-008 FIFO order SHALL be first-in first-out, and read/write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-009 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-010 IDLE -> START: at an edge with the FIFO non-empty, the FSM SHALL pop the head word into a 32-bit shift word, set byte index 0, and drive tx=0 from that edge.
REQ-011 START SHALL last CLKS_PER_BIT cycles with tx=0, then go to DATA.
REQ-012 DATA SHALL send 8 bits of the current byte, LSB first, each for CLKS_PER_BIT cycles.
REQ-013 STOP SHALL last CLKS_PER_BIT cycles with tx=1.
REQ-014 At the end of STOP with byte index<3, the FSM SHALL increment the index and go directly to START.
REQ-015 At the end of STOP with byte index=3, the FSM SHALL go to IDLE, or pop and go to START in the same edge if the FIFO is non-empty.
REQ-016 Bytes SHALL be sent least-significant first: byte0 = data_in[7:0] through byte3 = data_in[31:24].
REQ-017 One word SHALL occupy exactly 40*CLKS_PER_BIT cycles of tx, with no idle gap between its bytes.
REQ-018 The bit-period counter SHALL run 0..CLKS_PER_BIT-1 and wrap to 0 on each bit boundary.
REQ-019 tx SHALL be a registered output, with no combinational path from inputs.
REQ-020 Latency: for wr_en at edge N with the FIFO empty and FSM IDLE, tx SHALL fall at edge N+1.
REQ-021 full, empty and busy SHALL reflect registered state after each edge.

Reset
REQ-022 On rst=0, regardless of clk: tx=1, FSM=IDLE, FIFO count and pointers=0, empty=1, full=0, busy=0, overflow=0.
REQ-023 Reset during a frame SHALL abort the frame immediately and discard all buffered words; tx returns high asynchronously.
REQ-024 Writes presented in the first cycle after reset release SHALL be accepted normally.

Structure
REQ-025 FSM state encodings (2-bit) and the default CLKS_PER_BIT SHALL live in the shared package io_pkg.
REQ-026 The FIFO SHALL be a separate sub-module sync_fifo, parameterised on width and depth, with push, pop, full, empty and count ports.
REQ-027 serial_tx SHALL contain only the FSM, bit counter, shift register and overflow logic.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-028 Single word 0x44332211 -> tx frames for bytes 0x11, 0x22, 0x33, 0x44 in that order; total 160 cycles low-to-idle; busy drops the cycle after the final stop bit; empty=1.
REQ-029 Five back-to-back wr_en of 0xA0..0xA4 starting from idle -> first word popped at edge 2, so 0xA0..0xA4 all transmitted, no gap between words, overflow=0.
REQ-030 Six back-to-back writes while tx is mid-frame with 4 words queued -> the 2 extra words are dropped, overflow=1, and the 4 queued words are transmitted intact; clr_ovf then sets overflow=0.
REQ-031 Simultaneous wr_en and clr_ovf while full with no pop -> overflow remains 1.
REQ-032 rst asserted mid-DATA of byte 2 -> tx=1 immediately, empty=1, busy=0; a new write of 0x000000FF then transmits cleanly.
REQ-033 CLKS_PER_BIT=2 with word 0x00000000 -> 40 bits of 2 cycles each, with start bits low and stop bits high at the correct positions.

Source files
------------

// File: rtl/io_pkg.sv
// Shared definitions for the serial transmitter: FSM state encodings and default bit timing.
package io_pkg;
    localparam int DEFAULT_CLKS_PER_BIT = 434;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;
endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with head word visible on dout; one cycle write-to-visible latency.
// No internal protection: the owner gates push on full and pop on empty.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign dout  = mem[rd_ptr];
    assign full  = (cnt == CW'(DEPTH));
    assign empty = (cnt == '0);
    assign count = cnt;
endmodule

// File: rtl/serial_tx.sv
// Buffered 8N1 transmitter: each 32-bit word goes out as four bytes, LSB byte first; tx falls one edge after a write to an idle block.
// Writes are never stalled: a write to a full FIFO with no pop that cycle is dropped and flagged in the sticky overflow bit.
module serial_tx
    import io_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_in,
    input  logic        wr_en,
    input  logic        clr_ovf,
    output logic        tx,
    output logic        busy,
    output logic        full,
    output logic        empty,
    output logic        overflow
);
    localparam int          CW       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

    tx_state_t   state;
    tx_state_t   next_state;
    logic [15:0] bit_cnt;
    logic [2:0]  bit_idx;
    logic [1:0]  byte_idx;
    logic [31:0] shift;
    logic        tx_q;
    logic        tx_nxt;
    logic        ovf_q;
    logic        load;
    logic        push;
    logic        drop;
    logic        bit_end;
    logic [31:0] fifo_dout;
    logic        fifo_full;
    logic        fifo_empty;
    logic [CW-1:0] fifo_count;

    assign bit_end = (bit_cnt == BIT_LAST);
    assign push    = wr_en && ((fifo_count != CW'(FIFO_DEPTH)) || load);
    assign drop    = wr_en && !push;

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (load),
        .din   (data_in),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (!fifo_empty) next_state = ST_START;
            ST_START: if (bit_end) next_state = ST_DATA;
            ST_DATA:  if (bit_end && bit_idx == 3'd7) next_state = ST_STOP;
            ST_STOP: begin
                if (bit_end) begin
                    if (byte_idx != 2'd3 || !fifo_empty) next_state = ST_START;
                    else                                 next_state = ST_IDLE;
                end
            end
            default:  next_state = ST_IDLE;
        endcase
    end

    // tx_nxt is the line level for the bit that begins at the coming edge.
    always_comb begin
        load   = 1'b0;
        tx_nxt = tx_q;
        case (state)
            ST_IDLE: begin
                load   = !fifo_empty;
                tx_nxt = fifo_empty;
            end
            ST_START: if (bit_end) tx_nxt = shift[0];
            ST_DATA:  if (bit_end) tx_nxt = (bit_idx == 3'd7) ? 1'b1 : shift[1];
            ST_STOP: begin
                if (bit_end) begin
                    load   = (byte_idx == 2'd3) && !fifo_empty;
                    tx_nxt = (byte_idx == 2'd3) && fifo_empty;
                end
            end
            default: tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt  <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            shift    <= '0;
            tx_q     <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            tx_q  <= tx_nxt;
            ovf_q <= drop || (ovf_q && !clr_ovf);

            if (state == ST_IDLE || bit_end) bit_cnt <= '0;
            else                             bit_cnt <= bit_cnt + 16'd1;

            // Shifting right once per data bit leaves the next byte in shift[7:0].
            if (load)                             shift <= fifo_dout;
            else if (state == ST_DATA && bit_end) shift <= {1'b0, shift[31:1]};

            if (load)                                                byte_idx <= '0;
            else if (state == ST_STOP && bit_end && byte_idx != 2'd3) byte_idx <= byte_idx + 2'd1;

            if (state == ST_START)                bit_idx <= '0;
            else if (state == ST_DATA && bit_end) bit_idx <= bit_idx + 3'd1;
        end
    end

    assign tx       = tx_q;
    assign busy     = (state != ST_IDLE) || !fifo_empty;
    assign full     = fifo_full;
    assign empty    = fifo_empty;
    assign overflow = ovf_q;
endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: a 4-clock-per-bit instance decoded by a bench-side receiver, plus a 2-clock-per-bit instance checked bit by bit.
module tb_serial_tx;
    localparam int C1 = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data_in;
    logic        wr_en;
    logic        clr_ovf;
    logic        tx, busy, full, empty, overflow;

    logic [31:0] data_in2;
    logic        wr_en2, clr2;
    logic        tx2, busy2, full2, empty2, ovf2;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   last_start = 0;
    bit   chain = 1'b0;

    typedef struct {
        logic [31:0] data;
        logic [7:0]  b0, b1, b2, b3;
    } vec_t;
    vec_t vecs [4];

    logic [31:0] w;
    int          s;
    int          n;
    int          k0;
    logic [31:0] exp30 [5];
    logic [79:0] cap80, exp80;

    serial_tx #(.CLKS_PER_BIT(C1), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .wr_en(wr_en), .clr_ovf(clr_ovf),
        .tx(tx), .busy(busy), .full(full), .empty(empty), .overflow(overflow)
    );

    serial_tx #(.CLKS_PER_BIT(2), .FIFO_DEPTH(4)) dut2 (
        .clk(clk), .rst(rst), .data_in(data_in2), .wr_en(wr_en2), .clr_ovf(clr2),
        .tx(tx2), .busy(busy2), .full(full2), .empty(empty2), .overflow(ovf2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic write_word(input logic [31:0] d);
        wr_en   = 1'b1;
        data_in = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic rx_byte(output logic [7:0] b);
        int cnt;
        cnt = 0;
        b   = '0;
        while (tx !== 1'b0 && cnt < 3000) begin
            @(negedge clk);
            cnt++;
        end
        check("rx_start_seen", 80'(tx === 1'b0), 80'(1));
        if (chain) check("rx_byte_spacing", 80'(cyc - last_start), 80'(10 * C1));
        last_start = cyc;
        chain      = 1'b1;
        repeat (C1 / 2) @(negedge clk);
        check("rx_start_bit", 80'(tx), 80'(0));
        for (int i = 0; i < 8; i++) begin
            repeat (C1) @(negedge clk);
            b[i] = tx;
        end
        repeat (C1) @(negedge clk);
        check("rx_stop_bit", 80'(tx), 80'(1));
    endtask

    task automatic rx_word(output logic [31:0] wd, output int start);
        logic [7:0] b;
        wd    = '0;
        start = 0;
        for (int k = 0; k < 4; k++) begin
            rx_byte(b);
            if (k == 0) start = last_start;
            wd[8*k +: 8] = b;
        end
    endtask

    task automatic wait_idle(output int cnt);
        cnt = 0;
        while (busy !== 1'b0 && cnt < 1000) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    initial begin
        vecs[0] = '{32'h44332211, 8'h11, 8'h22, 8'h33, 8'h44};
        vecs[1] = '{32'hA5C30F81, 8'h81, 8'h0F, 8'hC3, 8'hA5};
        vecs[2] = '{32'hFFFFFFFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        vecs[3] = '{32'h00000000, 8'h00, 8'h00, 8'h00, 8'h00};
        exp30[0] = 32'hC0DE0000;
        for (int i = 1; i < 5; i++) exp30[i] = 32'hB0B00000 + 32'(i - 1);

        rst = 1'b1; wr_en = 1'b0; data_in = '0; clr_ovf = 1'b0;
        wr_en2 = 1'b0; data_in2 = '0; clr2 = 1'b0;
        #1 rst = 1'b0;
        #1;
        check("rst_tx", 80'(tx), 80'(1));
        check("rst_busy", 80'(busy), 80'(0));
        check("rst_empty", 80'(empty), 80'(1));
        check("rst_full", 80'(full), 80'(0));
        check("rst_overflow", 80'(overflow), 80'(0));
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Single words from idle: byte order, frame length, busy drop
        for (int v = 0; v < 4; v++) begin
            chain = 1'b0;
            write_word(vecs[v].data);
            rx_word(w, s);
            check($sformatf("vec%0d_byte0", v), 80'(w[7:0]),   80'(vecs[v].b0));
            check($sformatf("vec%0d_byte1", v), 80'(w[15:8]),  80'(vecs[v].b1));
            check($sformatf("vec%0d_byte2", v), 80'(w[23:16]), 80'(vecs[v].b2));
            check($sformatf("vec%0d_byte3", v), 80'(w[31:24]), 80'(vecs[v].b3));
            wait_idle(n);
            check($sformatf("vec%0d_busy_drop", v), 80'(busy), 80'(0));
            check($sformatf("vec%0d_frame_len", v), 80'(cyc - s), 80'(160));
            check($sformatf("vec%0d_empty", v), 80'(empty), 80'(1));
            check($sformatf("vec%0d_tx_idle", v), 80'(tx), 80'(1));
        end

        // Five back-to-back writes from idle
        chain = 1'b0;
        k0    = cyc;
        fork
            begin
                for (int i = 0; i < 5; i++) write_word(32'hA0 + 32'(i));
            end
            begin
                for (int i = 0; i < 5; i++) begin
                    rx_word(w, s);
                    if (i == 0) check("b2b_first_pop_edge", 80'(s - k0), 80'(2));
                    check($sformatf("b2b_word%0d", i), 80'(w), 80'(32'hA0 + 32'(i)));
                end
            end
        join
        check("b2b_overflow", 80'(overflow), 80'(0));
        wait_idle(n);
        check("b2b_idle", 80'(busy), 80'(0));

        // Overflow while mid-frame with the FIFO filled
        chain = 1'b0;
        fork
            begin
                write_word(32'hC0DE0000);
                repeat (20) @(negedge clk);
                for (int i = 0; i < 6; i++) write_word(32'hB0B00000 + 32'(i));
                check("ovf_full", 80'(full), 80'(1));
                check("ovf_set", 80'(overflow), 80'(1));
                wr_en = 1'b1; clr_ovf = 1'b1; data_in = 32'hBAD0BAD0;
                @(negedge clk);
                wr_en = 1'b0; clr_ovf = 1'b0;
                check("ovf_drop_beats_clear", 80'(overflow), 80'(1));
                clr_ovf = 1'b1;
                @(negedge clk);
                clr_ovf = 1'b0;
                check("ovf_cleared", 80'(overflow), 80'(0));
            end
            begin
                for (int i = 0; i < 5; i++) begin
                    rx_word(w, s);
                    check($sformatf("ovf_word%0d", i), 80'(w), 80'(exp30[i]));
                end
            end
        join
        wait_idle(n);
        check("ovf_drained_empty", 80'(empty), 80'(1));
        check("ovf_drained_busy", 80'(busy), 80'(0));

        // Reset in the middle of byte 2 with a second word queued
        write_word(32'h12345678);
        write_word(32'hDEADBEEF);
        repeat (95) @(negedge clk);
        check("midrst_busy_before", 80'(busy), 80'(1));
        #2 rst = 1'b0;
        #1;
        check("midrst_tx", 80'(tx), 80'(1));
        check("midrst_empty", 80'(empty), 80'(1));
        check("midrst_busy", 80'(busy), 80'(0));
        @(negedge clk);
        rst = 1'b1;
        chain = 1'b0;
        write_word(32'h000000FF);
        rx_word(w, s);
        check("midrst_new_word", 80'(w), 80'(32'h000000FF));
        wait_idle(n);
        check("midrst_no_stale_word", 80'(empty), 80'(1));
        check("midrst_final_busy", 80'(busy), 80'(0));

        // Two clocks per bit, all-zero word: start/stop positions
        wr_en2 = 1'b1; data_in2 = 32'h0;
        @(negedge clk);
        wr_en2 = 1'b0;
        cap80 = '0;
        exp80 = '0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            cap80[i] = tx2;
            exp80[i] = (((i / 2) % 10) == 9);
        end
        check("c2_frame_bits", cap80, exp80);
        @(negedge clk);
        check("c2_tx_idle", 80'(tx2), 80'(1));
        check("c2_busy", 80'(busy2), 80'(0));
        check("c2_empty", 80'(empty2), 80'(1));
        check("c2_full", 80'(full2), 80'(0));
        check("c2_overflow", 80'(ovf2), 80'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
